hazard_scoreboard: RTL and testbench
====================================

# hazard_scoreboard

Parametrised hazard/forwarding controller for the pipelined RV32I core. It tracks every in-flight register write from EX through WB in a shift-register scoreboard. From that it generates load-use and multi-cycle stalls, registered per-operand forwarding selects for the EX stage, and IF/ID and ID/EX squash on a taken branch or jump. It sits beside decode in the top level and drives the fetch hold, the pipeline-register enables and flushes, and the EX operand muxes.

## Interface
- `NREGS`, 32: architectural registers; index 0 is hardwired zero.
- `RIDX`, $clog2(NREGS): register index width.
- `DEPTH`, 3: tracked stages after decode. Stage 0 = EX, stage DEPTH-1 = WB.
- `FWD_EN`, 1: 1 = forwarding; 0 = stall until the producer has retired.
- `CNTW`, 32: performance counter width.
- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `id_valid_i` in 1: decode holds a real instruction.
- `id_rs1_i`, `id_rs2_i` in RIDX: source indices.
- `id_rs1_used_i`, `id_rs2_used_i` in 1: operand is actually read.
- `id_rd_i` in RIDX: destination.
- `id_regwren_i` in 1: instruction writes rd.
- `id_avail_i` in AVW=$clog2(DEPTH): stage at whose end the result exists. ALU = 0, load = 1.
- `ex_redirect_i` in 1: instruction in EX resolved a taken branch or jump this cycle.
- `stall_o` out 1: hold PC and IF/ID this cycle.
- `if_id_flush_o` out 1: load NOP into IF/ID.
- `id_ex_bubble_o` out 1: load bubble into ID/EX.
- `fwd_rs1_sel_o`, `fwd_rs2_sel_o` out FSW=$clog2(DEPTH+1): registered EX operand source. 0 = regfile, k = result held in stage-k pipeline register.
- `stall_cnt_o`, `flush_cnt_o` out CNTW: saturating event counters.

## Operation
- Scoreboard: DEPTH entries of {valid, rd, avail}. Entry k is the instruction in stage k.
- An entry is recorded only if `id_valid_i & id_regwren_i & id_rd_i != 0`. Otherwise it is inserted as invalid.
- Match rules for each used operand with nonzero src:
  - Select the youngest (lowest k) valid entry with rd == src.
  - Producer at k when the consumer enters EX at k+1.
- FWD_EN=1:
  - No match: sel = 0.
  - Match with k >= avail: sel = k+1, or 0 if k+1 == DEPTH (producer retired to regfile).
  - Match with k < avail: hazard.
- FWD_EN=0: any match with k+1 < DEPTH is a hazard.
- `stall_o` = `id_valid_i & hazard & !ex_redirect_i`.
- `if_id_flush_o` = `ex_redirect_i`.
- `id_ex_bubble_o` = `stall_o | ex_redirect_i`.
- Per-cycle update:
  - All entries shift k → k+1; entry DEPTH-1 drops.
  - Entry 0 ← the decode instruction if neither stall nor redirect, else invalid.
- Redirect outranks stall: the stalled decode instruction is wrong-path and is discarded. The branch itself (entry 0) keeps shifting.
- Forward selects register in the same update; they are forced to 0 when entry 0 becomes a bubble.
- Counters: +1 per cycle with `stall_o`, +1 per cycle with `ex_redirect_i`. Both hold at all-ones.
- The register file does not bypass same-cycle writes; the WB-stage value is reached only via sel = DEPTH-1.

## Timing
- Reset: all entries invalid, both `fwd_*_sel_o` = 0, counters = 0.
- `stall_o`, `if_id_flush_o`, `id_ex_bubble_o` are combinational from inputs and scoreboard state in the same cycle.
- Forward selects appear one cycle after decode, aligned with the consumer in EX.
- Load-use stall is one cycle for avail=1 and DEPTH=3. In general a stall lasts avail-k cycles.
- With FWD_EN=0 the stall lasts until the producer leaves stage DEPTH-1.
- `rst` asserted mid-stall clears the scoreboard; `stall_o` is 0 in the next cycle.
- `rst` outranks `ex_redirect_i` and all counter updates.

## Structure
- Package `hazard_pkg`:
  - `sb_entry_t` struct {valid, rd, avail}.
  - `FWD_REGFILE` = 0 constant.
  - Function computing match/hazard/sel for one operand.
- Sub-module `hazard_src_check`: one instance per operand. It is combinational and scans the entries youngest-first.
- Top-level `hazard_scoreboard` holds the shift register, the output registers and the counters.

## Test plan
- `addi x1,x0,5` then `add x2,x1,x1` back-to-back, FWD_EN=1: no stall; next cycle `fwd_rs1_sel_o` = `fwd_rs2_sel_o` = 1.
- `lw x3,0(x4)` then `add x5,x3,x0`: `stall_o`=1 for exactly 1 cycle; then `fwd_rs1_sel_o`=2 in EX; `stall_cnt_o`=1.
- Producer `x6` then two independents then consumer of `x6` (DEPTH=3): no stall, sel=0. Producer to `x0` then consumer of `x0`: no stall, sel=0.
- FWD_EN=0, `addi x1` then `add x2,x1`: `stall_o`=1 for 2 cycles, then sel=0.
- Load-use stall coincident with `ex_redirect_i`=1: `stall_o`=0, `if_id_flush_o`=1, `id_ex_bubble_o`=1; entry 0 invalid next cycle; `flush_cnt_o`=1.
- `rst` during a load-use stall: outputs, counters and selects all 0 next cycle; a subsequent consumer of the old rd sees no hazard.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and the per-entry operand check for the hazard scoreboard.
// Field widths are sized for the RV32I core: 32 registers and up to 3 tracked stages.
package hazard_pkg;

    localparam int SB_RD_W  = 5;
    localparam int SB_AV_W  = 2;
    localparam int SB_SEL_W = 2;

    localparam logic [SB_SEL_W-1:0] FWD_REGFILE = '0;

    typedef struct packed {
        logic                valid;
        logic [SB_RD_W-1:0]  rd;
        logic [SB_AV_W-1:0]  avail;
    } sb_entry_t;

    typedef struct packed {
        logic                match;
        logic                hazard;
        logic [SB_SEL_W-1:0] sel;
    } src_res_t;

    // The producer in entry k is in stage k+1 once the consumer reaches EX.
    function automatic src_res_t check_entry(
        input sb_entry_t          e,
        input int                 k,
        input logic [SB_RD_W-1:0] src,
        input int                 depth,
        input bit                 fwd_en
    );
        src_res_t r;
        r       = '0;
        r.sel   = FWD_REGFILE;
        r.match = e.valid && (e.rd == src) && (src != '0);
        if (r.match) begin
            if (fwd_en) begin
                if (k >= int'(e.avail)) begin
                    if (k + 1 < depth)
                        r.sel = SB_SEL_W'(k + 1);
                end else begin
                    r.hazard = 1'b1;
                end
            end else begin
                r.hazard = (k + 1 < depth);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/hazard_src_check.sv
// Combinational hazard/forward evaluation of one source operand against the scoreboard.
module hazard_src_check
    import hazard_pkg::*;
#(
    parameter int DEPTH  = 3,
    parameter bit FWD_EN = 1'b1
) (
    input  sb_entry_t            entries [DEPTH],
    input  logic [SB_RD_W-1:0]   src,
    input  logic                 used,
    output logic                 hazard,
    output logic [SB_SEL_W-1:0]  sel
);

    src_res_t res;
    logic     found;

    // Youngest entry wins: stop at the first match scanning from stage 0.
    always_comb begin
        hazard = 1'b0;
        sel    = FWD_REGFILE;
        found  = 1'b0;
        res    = '0;
        for (int k = 0; k < DEPTH; k++) begin
            res = check_entry(entries[k], k, src, DEPTH, FWD_EN);
            if (!found && res.match) begin
                found  = 1'b1;
                hazard = res.hazard & used;
                sel    = used ? res.sel : FWD_REGFILE;
            end
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// In-flight write scoreboard driving stalls, squashes and registered EX forward selects.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter  int NREGS  = 32,
    parameter  int RIDX   = $clog2(NREGS),
    parameter  int DEPTH  = 3,
    parameter  bit FWD_EN = 1'b1,
    parameter  int CNTW   = 32,
    localparam int AVW    = $clog2(DEPTH),
    localparam int FSW    = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid_i,
    input  logic [RIDX-1:0] id_rs1_i,
    input  logic [RIDX-1:0] id_rs2_i,
    input  logic            id_rs1_used_i,
    input  logic            id_rs2_used_i,
    input  logic [RIDX-1:0] id_rd_i,
    input  logic            id_regwren_i,
    input  logic [AVW-1:0]  id_avail_i,
    input  logic            ex_redirect_i,
    output logic            stall_o,
    output logic            if_id_flush_o,
    output logic            id_ex_bubble_o,
    output logic [FSW-1:0]  fwd_rs1_sel_o,
    output logic [FSW-1:0]  fwd_rs2_sel_o,
    output logic [CNTW-1:0] stall_cnt_o,
    output logic [CNTW-1:0] flush_cnt_o
);

    sb_entry_t           sb [DEPTH];
    sb_entry_t           id_entry;
    logic                rs1_hazard, rs2_hazard;
    logic [SB_SEL_W-1:0] rs1_sel, rs2_sel;
    logic                ex_is_bubble;

    hazard_src_check #(.DEPTH(DEPTH), .FWD_EN(FWD_EN)) u_rs1_check (
        .entries (sb),
        .src     (SB_RD_W'(id_rs1_i)),
        .used    (id_rs1_used_i),
        .hazard  (rs1_hazard),
        .sel     (rs1_sel)
    );

    hazard_src_check #(.DEPTH(DEPTH), .FWD_EN(FWD_EN)) u_rs2_check (
        .entries (sb),
        .src     (SB_RD_W'(id_rs2_i)),
        .used    (id_rs2_used_i),
        .hazard  (rs2_hazard),
        .sel     (rs2_sel)
    );

    always_comb begin
        id_entry.valid = id_valid_i & id_regwren_i & (id_rd_i != '0);
        id_entry.rd    = SB_RD_W'(id_rd_i);
        id_entry.avail = SB_AV_W'(id_avail_i);
    end

    // Redirect outranks stall: a stalled decode slot is wrong-path anyway.
    assign stall_o        = id_valid_i & (rs1_hazard | rs2_hazard) & ~ex_redirect_i;
    assign if_id_flush_o  = ex_redirect_i;
    assign id_ex_bubble_o = stall_o | ex_redirect_i;
    assign ex_is_bubble   = id_ex_bubble_o | ~id_valid_i;

    // NOTE: all state here uses non-blocking assignments so every stage samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++)
                sb[k] <= '0;
            fwd_rs1_sel_o <= '0;
            fwd_rs2_sel_o <= '0;
            stall_cnt_o   <= '0;
            flush_cnt_o   <= '0;
        end else begin
            for (int k = DEPTH - 1; k > 0; k--)
                sb[k] <= sb[k-1];
            sb[0]         <= id_ex_bubble_o ? '0 : id_entry;
            fwd_rs1_sel_o <= ex_is_bubble ? '0 : FSW'(rs1_sel);
            fwd_rs2_sel_o <= ex_is_bubble ? '0 : FSW'(rs2_sel);
            if (stall_o && (stall_cnt_o != '1))
                stall_cnt_o <= stall_cnt_o + 1'b1;
            if (ex_redirect_i && (flush_cnt_o != '1))
                flush_cnt_o <= flush_cnt_o + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench: a forwarding instance (32-bit counters) and a no-forwarding instance (2-bit counters).
module tb_hazard_scoreboard;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic       id_rs1_used, id_rs2_used, id_regwren;
    logic [1:0] id_avail;
    logic       ex_redirect;

    logic        f_stall, f_flush, f_bubble;
    logic [1:0]  f_sel1, f_sel2;
    logic [31:0] f_scnt, f_fcnt;
    logic        n_stall, n_flush, n_bubble;
    logic [1:0]  n_sel1, n_sel2;
    logic [1:0]  n_scnt, n_fcnt;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    hazard_scoreboard #(.FWD_EN(1'b1)) u_fwd (
        .clk(clk), .rst(rst), .id_valid_i(id_valid),
        .id_rs1_i(id_rs1), .id_rs2_i(id_rs2),
        .id_rs1_used_i(id_rs1_used), .id_rs2_used_i(id_rs2_used),
        .id_rd_i(id_rd), .id_regwren_i(id_regwren), .id_avail_i(id_avail),
        .ex_redirect_i(ex_redirect),
        .stall_o(f_stall), .if_id_flush_o(f_flush), .id_ex_bubble_o(f_bubble),
        .fwd_rs1_sel_o(f_sel1), .fwd_rs2_sel_o(f_sel2),
        .stall_cnt_o(f_scnt), .flush_cnt_o(f_fcnt)
    );

    hazard_scoreboard #(.FWD_EN(1'b0), .CNTW(2)) u_nofwd (
        .clk(clk), .rst(rst), .id_valid_i(id_valid),
        .id_rs1_i(id_rs1), .id_rs2_i(id_rs2),
        .id_rs1_used_i(id_rs1_used), .id_rs2_used_i(id_rs2_used),
        .id_rd_i(id_rd), .id_regwren_i(id_regwren), .id_avail_i(id_avail),
        .ex_redirect_i(ex_redirect),
        .stall_o(n_stall), .if_id_flush_o(n_flush), .id_ex_bubble_o(n_bubble),
        .fwd_rs1_sel_o(n_sel1), .fwd_rs2_sel_o(n_sel2),
        .stall_cnt_o(n_scnt), .flush_cnt_o(n_fcnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; combinational checks follow 1 unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] rs1, input logic u1,
                         input logic [4:0] rs2, input logic u2,
                         input logic [4:0] rd, input logic wr, input logic [1:0] av,
                         input logic redir);
        id_valid = v;  id_rs1 = rs1; id_rs1_used = u1; id_rs2 = rs2; id_rs2_used = u2;
        id_rd = rd; id_regwren = wr; id_avail = av; ex_redirect = redir;
        #1;
    endtask

    task automatic idle(input int n);
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 2'd0, 1'b0);
        repeat (n) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        do_reset();
        check("reset_stall", f_stall, 0);
        check("reset_sel1", f_sel1, 0);
        check("reset_stall_cnt", f_scnt, 0);
        check("reset_flush_cnt", f_fcnt, 0);

        // addi x1,x0,5 ; add x2,x1,x1
        drive(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd1, 1'b1, 2'd0, 1'b0);
        check("alu_prod_stall", f_stall, 0);
        tick();
        drive(1'b1, 5'd1, 1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 2'd0, 1'b0);
        check("alu_use_stall", f_stall, 0);
        tick();
        check("alu_use_sel1", f_sel1, 1);
        check("alu_use_sel2", f_sel2, 1);
        idle(3);

        // lw x3,0(x4) ; add x5,x3,x0
        drive(1'b1, 5'd4, 1'b1, 5'd0, 1'b0, 5'd3, 1'b1, 2'd1, 1'b0);
        tick();
        drive(1'b1, 5'd3, 1'b1, 5'd0, 1'b1, 5'd5, 1'b1, 2'd0, 1'b0);
        check("load_use_stall", f_stall, 1);
        check("load_use_bubble", f_bubble, 1);
        check("load_use_flush", f_flush, 0);
        tick();
        check("load_use_stall_cyc2", f_stall, 0);
        tick();
        check("load_use_sel1", f_sel1, 2);
        check("load_use_sel2_x0", f_sel2, 0);
        check("load_use_stall_cnt", f_scnt, 1);
        idle(3);

        // x6 producer, two independents, consumer of x6: producer retired to regfile
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd6, 1'b1, 2'd0, 1'b0);
        tick();
        drive(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 2'd0, 1'b0);
        tick();
        drive(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 2'd0, 1'b0);
        tick();
        drive(1'b1, 5'd6, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 2'd0, 1'b0);
        check("dist3_stall", f_stall, 0);
        tick();
        check("dist3_sel1", f_sel1, 0);
        // write to x0 then read x0
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 2'd1, 1'b0);
        tick();
        drive(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd10, 1'b1, 2'd0, 1'b0);
        check("x0_stall", f_stall, 0);
        tick();
        check("x0_sel1", f_sel1, 0);
        idle(3);

        // Load-use coincident with a redirect: consumer discarded as wrong-path
        drive(1'b1, 5'd4, 1'b1, 5'd0, 1'b0, 5'd3, 1'b1, 2'd1, 1'b0);
        tick();
        drive(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 2'd0, 1'b1);
        check("redir_stall", f_stall, 0);
        check("redir_flush", f_flush, 1);
        check("redir_bubble", f_bubble, 1);
        tick();
        check("redir_sel1", f_sel1, 0);
        check("redir_flush_cnt", f_fcnt, 1);
        check("redir_stall_cnt", f_scnt, 1);
        // x5 must not have been recorded; otherwise this would forward from stage 1
        drive(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd11, 1'b1, 2'd0, 1'b0);
        check("redir_entry0_stall", f_stall, 0);
        tick();
        check("redir_entry0_sel1", f_sel1, 0);
        idle(3);

        // Reset in the middle of an avail=2 load-use stall
        drive(1'b1, 5'd4, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 2'd2, 1'b0);
        tick();
        drive(1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 5'd12, 1'b1, 2'd0, 1'b0);
        check("avail2_stall_cyc1", f_stall, 1);
        tick();
        check("avail2_stall_cyc2", f_stall, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("rst_mid_stall", f_stall, 0);
        check("rst_mid_bubble", f_bubble, 0);
        check("rst_mid_stall_cnt", f_scnt, 0);
        check("rst_mid_flush_cnt", f_fcnt, 0);
        check("rst_mid_sel1", f_sel1, 0);
        tick();
        check("rst_after_sel1", f_sel1, 0);
        idle(3);

        // No-forwarding instance: addi x1 ; add x2,x1 stalls two cycles, twice (counter saturates at 3)
        do_reset();
        check("nofwd_reset_cnt", n_scnt, 0);
        for (int rep = 0; rep < 2; rep++) begin
            drive(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd1, 1'b1, 2'd0, 1'b0);
            tick();
            drive(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd2, 1'b1, 2'd0, 1'b0);
            check("nofwd_stall_c1", n_stall, 1);
            check("nofwd_bubble_c1", n_bubble, 1);
            tick();
            check("nofwd_stall_c2", n_stall, 1);
            tick();
            check("nofwd_stall_c3", n_stall, 0);
            tick();
            check("nofwd_sel1", n_sel1, 0);
            check("nofwd_stall_cnt", n_scnt, (rep == 0) ? 2 : 3);
            idle(3);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
